fifo_rd_stream: RTL
===================

Name: fifo_rd_stream

Overview:
- Downstream stage of the synchronous FIFO (128-bit, 1024 deep). Drains the FIFO's 1-cycle-latency read port and presents the data as a valid/ready stream to the consumer logic.
- Holds the prefetched words in a 2-entry output buffer. Read latency and consumer backpressure never drop or duplicate a word.
- Keeps a running count of words delivered and supports a synchronous flush.

Parameters:
- DATA_W, 128, data word width; matches the FIFO data width.
- CNT_W, 32, width of the delivered-word counter.

Ports:
- clk  input  1  clock; all state changes on its rising edge.
- rstn  input  1  synchronous active-low reset, sampled on rising clk.
- i_clr  input  1  synchronous flush of buffer and in-flight read; the counter is kept.
- i_fifo_empty  input  1  FIFO empty flag.
- i_fifo_rddata  input  DATA_W  FIFO read data; valid in the cycle after an accepted read.
- o_fifo_rden  output  1  FIFO read enable (combinational).
- o_valid  output  1  output word available.
- i_ready  input  1  consumer accepts the word when o_valid && i_ready.
- o_data  output  DATA_W  output word (buffer head).
- o_rd_count  output  CNT_W  words delivered since reset.

Behaviour:
- Single clock domain (clk). Reset is synchronous and active-low (rstn sampled on the rising edge); there is no asynchronous reset path.
- Reset values:
  - o_valid=0, o_data=0, o_rd_count=0.
  - Buffer occupancy occ=0; in-flight flag infl=0; buffer storage cleared.
  - o_fifo_rden=0 while rstn=0.
- FIFO contract: a read is accepted at edge N when o_fifo_rden=1 and i_fifo_empty=0. i_fifo_rddata carries the word during cycle N+1 and is captured at edge N+1.
- infl register:
  - Set at any edge where a read is accepted.
  - Otherwise cleared, because the data lands on the next edge.
- pop = o_valid && i_ready.
- Read issue (combinational):
  - o_fifo_rden = rstn && !i_clr && !i_fifo_empty && (occ + infl - pop) < 2.
  - The pop credit gives one word per cycle in steady state. The path i_ready -> o_fifo_rden is accepted as combinational.
  - Invariant: occ + infl <= 2 at every edge. Buffer overflow is impossible.
- Buffer: 2-entry FIFO of registers.
  - o_data = head entry; o_valid = (occ != 0).
  - Push at edge N+1 when infl=1; push and pop may occur on the same edge.
  - Pop and push with occ=1: the head is replaced by the landing word.
  - occ=2 and pop: entry 1 shifts to head.
  - o_data and o_valid stay stable while o_valid=1 && i_ready=0.
  - o_data holds its last value when occ=0 (not cleared).
- Counter: o_rd_count increments by 1 on each pop and wraps modulo 2^CNT_W.
- Flush (i_clr=1 at edge E):
  - occ -> 0 and o_valid=0 after E.
  - No read issued in the flush cycle.
  - A word landing at E (infl=1) is discarded.
  - infl cleared after E.
  - Counter unchanged; a pop in the same cycle as i_clr is not counted.
  - Normal issue resumes the cycle after i_clr deasserts.
- Reset mid-operation (rstn=0 at any edge): all state returns to reset values, in-flight data is discarded, and o_fifo_rden=0 for the whole reset cycle.
- Empty FIFO: o_fifo_rden stays 0 and no bubble words are produced. o_valid drops once the buffer drains.

Test Plan:
- Reset then FIFO holding 0x1,0x2,0x3 with i_ready=1 -> o_fifo_rden high at cycles 1,2,3. o_valid from cycle 2 with o_data 0x1,0x2,0x3 on consecutive cycles. o_rd_count=3, then o_valid=0.
- FIFO holding 5 words with i_ready=0 -> exactly 2 reads issued, occ=2, o_data=word0 held stable. Raise i_ready -> remaining words arrive in order, no loss or duplication, o_rd_count=5.
- i_ready toggling 1,0,1,0 over 8 words -> output order word0..word7 exactly, o_rd_count=8, occ never exceeds 2.
- i_clr asserted the cycle after a read is accepted with occ=1 -> o_valid=0 next cycle. The landing word is dropped. o_rd_count unchanged. Next output is the following FIFO word.
- rstn=0 mid-stream with occ=2 and infl=1 -> after the reset edge o_valid=0, o_data=0, o_rd_count=0, o_fifo_rden=0 during reset, and the first word after reset is the current FIFO head.
- o_rd_count preloaded to 0xFFFFFFFF by forcing, then one pop -> o_rd_count=0x00000000.

Source files
------------

// File: rtl/fifo_rd_stream.sv
// Read-side stream adapter for the 128x1024 synchronous FIFO: turns the FIFO's
// 1-cycle-latency read port into a valid/ready stream through a 2-entry buffer.
module fifo_rd_stream #(
  parameter int DATA_W = 128,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              i_clr,
  input  logic              i_fifo_empty,
  input  logic [DATA_W-1:0] i_fifo_rddata,
  output logic              o_fifo_rden,
  output logic              o_valid,
  input  logic              i_ready,
  output logic [DATA_W-1:0] o_data,
  output logic [CNT_W-1:0]  o_rd_count
);

  logic [1:0]        occ;
  logic              infl;
  logic [DATA_W-1:0] head;
  logic [DATA_W-1:0] tail;
  logic [CNT_W-1:0]  rd_count;

  logic       pop;
  logic       push;
  logic       rd_acc;
  logic [1:0] level;

  assign o_valid    = (occ != 2'd0);
  assign o_data     = head;
  assign o_rd_count = rd_count;

  assign pop  = o_valid && i_ready;
  assign push = infl;

  // Words owned after this edge; the pop credit keeps one read per cycle in steady state.
  // Cannot underflow (pop needs occ>=1) and never exceeds 2, so 2 bits suffice.
  assign level = occ + {1'b0, infl} - {1'b0, pop};

  assign o_fifo_rden = rstn && !i_clr && !i_fifo_empty && (level < 2'd2);
  assign rd_acc      = o_fifo_rden && !i_fifo_empty;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      occ      <= 2'd0;
      infl     <= 1'b0;
      head     <= '0;
      tail     <= '0;
      rd_count <= '0;
    end else if (i_clr) begin
      // Storage is left alone so o_data keeps showing its last value.
      occ  <= 2'd0;
      infl <= 1'b0;
    end else begin
      infl <= rd_acc;
      if (pop) begin
        rd_count <= rd_count + CNT_W'(1);
      end
      case ({push, pop})
        2'b10: begin
          if (occ == 2'd0) begin
            head <= i_fifo_rddata;
          end else begin
            tail <= i_fifo_rddata;
          end
          occ <= occ + 2'd1;
        end
        2'b01: begin
          if (occ == 2'd2) begin
            head <= tail;
          end
          occ <= occ - 2'd1;
        end
        2'b11: begin
          // Occupancy unchanged: the landing word takes the slot the popped word frees.
          if (occ == 2'd1) begin
            head <= i_fifo_rddata;
          end else begin
            head <= tail;
            tail <= i_fifo_rddata;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule
